// File: rtl/ahb_output_stage_arb.sv
// AHB bus-matrix output stage: round-robin arbitration of 3 decoder ports onto one slave.
// Optional AHB_OUT_LOCK_EN: HMASTLOCK from the owner holds the grant through locked sequences.
module ahb_output_stage_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,

  input  logic              sel_op0,
  input  logic [ADDR_W-1:0] addr_op0,
  input  logic [1:0]        trans_op0,
  input  logic              write_op0,
  input  logic [2:0]        size_op0,
  input  logic [2:0]        burst_op0,
  input  logic [3:0]        prot_op0,
  input  logic [3:0]        master_op0,
  input  logic              mastlock_op0,
  input  logic [DATA_W-1:0] wdata_op0,
  output logic              active_op0,

  input  logic              sel_op1,
  input  logic [ADDR_W-1:0] addr_op1,
  input  logic [1:0]        trans_op1,
  input  logic              write_op1,
  input  logic [2:0]        size_op1,
  input  logic [2:0]        burst_op1,
  input  logic [3:0]        prot_op1,
  input  logic [3:0]        master_op1,
  input  logic              mastlock_op1,
  input  logic [DATA_W-1:0] wdata_op1,
  output logic              active_op1,

  input  logic              sel_op2,
  input  logic [ADDR_W-1:0] addr_op2,
  input  logic [1:0]        trans_op2,
  input  logic              write_op2,
  input  logic [2:0]        size_op2,
  input  logic [2:0]        burst_op2,
  input  logic [3:0]        prot_op2,
  input  logic [3:0]        master_op2,
  input  logic              mastlock_op2,
  input  logic [DATA_W-1:0] wdata_op2,
  output logic              active_op2,

  output logic              HSELM,
  output logic [ADDR_W-1:0] HADDRM,
  output logic [1:0]        HTRANSM,
  output logic              HWRITEM,
  output logic [2:0]        HSIZEM,
  output logic [2:0]        HBURSTM,
  output logic [3:0]        HPROTM,
  output logic [3:0]        HMASTERM,
  output logic              HMASTLOCKM,
  output logic [DATA_W-1:0] HWDATAM,
  output logic              HREADYMUXM,
  input  logic              HREADYOUTM
);

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_BUSY = 2'b01;
  localparam logic [1:0] TR_SEQ  = 2'b11;

  logic [1:0] addr_port;
  logic       no_port;
  logic [1:0] data_port;
  logic       data_valid;

  logic [1:0] next_port;
  logic       next_no_port;
  logic [3:0] sel_v;
  logic [3:0] req_v;
  logic [3:0] lock_v;
  logic [1:0] trans_owner;
  logic       lock_hold;
  logic       hold;

  function automatic logic [1:0] rr_step(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign sel_v  = {1'b0, sel_op2, sel_op1, sel_op0};
  assign req_v  = sel_v & {1'b0, trans_op2 != TR_IDLE, trans_op1 != TR_IDLE, trans_op0 != TR_IDLE};
  assign lock_v = {1'b0, mastlock_op2, mastlock_op1, mastlock_op0};

  always_comb begin
    trans_owner = TR_IDLE;
    case (addr_port)
      2'd0:    trans_owner = trans_op0;
      2'd1:    trans_owner = trans_op1;
      2'd2:    trans_owner = trans_op2;
      default: trans_owner = TR_IDLE;
    endcase
  end

`ifdef AHB_OUT_LOCK_EN
  assign lock_hold  = lock_v[addr_port];
  assign HMASTLOCKM = ~next_no_port & lock_v[next_port];
`else
  logic unused_lock;
  assign unused_lock = ^lock_v;
  assign lock_hold   = 1'b0;
  assign HMASTLOCKM  = 1'b0;
`endif

  // An unfinished burst (BUSY/SEQ) or a locked sequence keeps the current owner.
  assign hold = ~no_port & sel_v[addr_port] &
                ((trans_owner == TR_BUSY) | (trans_owner == TR_SEQ) | lock_hold);

  always_comb begin
    logic [1:0] c1;
    logic [1:0] c2;
    c1           = rr_step(addr_port);
    c2           = rr_step(c1);
    next_port    = addr_port;
    next_no_port = 1'b0;
    if (hold)                 next_port = addr_port;
    else if (req_v[c1])       next_port = c1;
    else if (req_v[c2])       next_port = c2;
    else if (req_v[addr_port]) next_port = addr_port;
    else                      next_no_port = 1'b1;
  end

  assign active_op0 = ~next_no_port & (next_port == 2'd0);
  assign active_op1 = ~next_no_port & (next_port == 2'd1);
  assign active_op2 = ~next_no_port & (next_port == 2'd2);
  assign HSELM      = ~next_no_port;

  always_comb begin
    HADDRM   = addr_op0;
    HTRANSM  = trans_op0;
    HWRITEM  = write_op0;
    HSIZEM   = size_op0;
    HBURSTM  = burst_op0;
    HPROTM   = prot_op0;
    HMASTERM = master_op0;
    case (next_port)
      2'd1: begin
        HADDRM   = addr_op1;
        HTRANSM  = trans_op1;
        HWRITEM  = write_op1;
        HSIZEM   = size_op1;
        HBURSTM  = burst_op1;
        HPROTM   = prot_op1;
        HMASTERM = master_op1;
      end
      2'd2: begin
        HADDRM   = addr_op2;
        HTRANSM  = trans_op2;
        HWRITEM  = write_op2;
        HSIZEM   = size_op2;
        HBURSTM  = burst_op2;
        HPROTM   = prot_op2;
        HMASTERM = master_op2;
      end
      default: ;
    endcase
    if (next_no_port) HTRANSM = TR_IDLE;
  end

  always_comb begin
    HWDATAM = wdata_op0;
    case (data_port)
      2'd1:    HWDATAM = wdata_op1;
      2'd2:    HWDATAM = wdata_op2;
      default: HWDATAM = wdata_op0;
    endcase
  end

  assign HREADYMUXM = data_valid ? HREADYOUTM : 1'b1;

  // Everything freezes while the slave stretches a data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_port  <= 2'd0;
      no_port    <= 1'b1;
      data_port  <= 2'd0;
      data_valid <= 1'b0;
    end else if (HREADYMUXM) begin
      addr_port  <= next_port;
      no_port    <= next_no_port;
      data_port  <= next_port;
      data_valid <= HSELM & (HTRANSM != TR_IDLE);
    end
  end

endmodule
